// File: rtl/irrigation_mode_controller.sv
// Irrigation mode FSM: settle dead-time, minimum run, latched sensor fault.
// Optional run timeout: define IRRIGATION_RUN_TIMEOUT_EN.
module irrigation_mode_controller #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int MIN_RUN_CYCLES = 16,
  parameter int MAX_RUN_CYCLES = 200,
  parameter int CNT_W          = 8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic soil_dry_i,
  input  logic soil_wet_i,
  input  logic air_dry_i,
  input  logic tank_empty_i,
  output logic sprinkler_status_o,
  output logic drip_status_o,
  output logic valve_open_o,
  output logic fault_o,
  output logic timeout_o
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, SPRINK, DRIP, FAULT
  } state_t;

  typedef enum logic [1:0] {
    T_NONE, T_HOLD, T_SPR, T_DRIP
  } tgt_t;

  localparam int LIM = 1 << CNT_W;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LD = CNT_W'(MIN_RUN_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES >= LIM ||
      MIN_RUN_CYCLES < 1 || MIN_RUN_CYCLES >= LIM ||
      MAX_RUN_CYCLES < 1 || MAX_RUN_CYCLES >= LIM) begin : g_bad_param
    $error("irrigation_mode_controller: parameter out of range");
  end

  state_t           state;
  state_t           pend;
  state_t           tgt_st;
  tgt_t             tgt;
  logic [CNT_W-1:0] set_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             to_q;
  logic             to_fire;
  logic             fault_in;
  logic             stop;
  logic             tgt_off;
  logic             tgt_mode;
  logic             in_run;
  logic             run_done;

  assign fault_in = soil_dry_i & soil_wet_i;
  assign stop     = !enable_i | tank_empty_i;
  assign tgt_off  = stop | soil_wet_i | to_q;
  assign in_run   = (state == SPRINK) | (state == DRIP);
  assign run_done = (run_cnt == '0);
  assign tgt_mode = (tgt == T_SPR) | (tgt == T_DRIP);
  assign tgt_st   = (tgt == T_DRIP) ? DRIP : SPRINK;

  always_comb begin
    tgt = T_HOLD;
    unique case (1'b1)
      tgt_off:                             tgt = T_NONE;
      !tgt_off && soil_dry_i && air_dry_i:  tgt = T_DRIP;
      !tgt_off && soil_dry_i && !air_dry_i: tgt = T_SPR;
      !tgt_off && !soil_dry_i:              tgt = T_HOLD;
      default:                             tgt = T_HOLD;
    endcase
  end

`ifdef IRRIGATION_RUN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] MAX_LD = CNT_W'(MAX_RUN_CYCLES - 1);

  logic [CNT_W-1:0] age_cnt;

  // age counts cycles already spent in the current run
  assign to_fire = in_run & !fault_in & !stop & (age_cnt == MAX_LD);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      age_cnt <= '0;
      to_q    <= 1'b0;
    end else begin
      if (!in_run)
        age_cnt <= '0;
      else if (age_cnt != '1)
        age_cnt <= age_cnt + ONE;
      if (soil_wet_i || !enable_i)
        to_q <= 1'b0;
      else if (to_fire)
        to_q <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign to_q    = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state              <= IDLE;
      pend               <= SPRINK;
      set_cnt            <= '0;
      run_cnt            <= '0;
      sprinkler_status_o <= 1'b0;
      drip_status_o      <= 1'b0;
      valve_open_o       <= 1'b0;
      fault_o            <= 1'b0;
      timeout_o          <= 1'b0;
    end else begin
      sprinkler_status_o <= (state == SPRINK);
      drip_status_o      <= (state == DRIP);
      valve_open_o       <= in_run;
      fault_o            <= (state == FAULT);
      timeout_o          <= to_q;
      if (fault_in) begin
        state <= FAULT;
      end else begin
        unique case (state)
          IDLE: begin
            if (tgt_mode) begin
              state   <= SETTLE;
              pend    <= tgt_st;
              set_cnt <= SET_LD;
            end
          end
          SETTLE: begin
            if (tgt == T_NONE) begin
              state <= IDLE;
            end else if (tgt_mode && tgt_st != pend) begin
              pend    <= tgt_st;
              set_cnt <= SET_LD;
            end else if (set_cnt == '0) begin
              state   <= pend;
              run_cnt <= RUN_LD;
            end else begin
              set_cnt <= set_cnt - ONE;
            end
          end
          SPRINK, DRIP: begin
            if (!run_done)
              run_cnt <= run_cnt - ONE;
            if (stop || to_fire) begin
              state <= IDLE;
            end else if (run_done && soil_wet_i) begin
              state <= IDLE;
            end else if (run_done && tgt_mode &&
                         tgt_st != state) begin
              state   <= SETTLE;
              pend    <= tgt_st;
              set_cnt <= SET_LD;
            end
          end
          FAULT: begin
            if (!enable_i)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irrigation_mode_controller.sv
// Bench for irrigation_mode_controller: directed table plus
// randomized run against a behavioural model.
module tb_irrigation_mode_controller;

  localparam int S  = 4;
  localparam int MN = 16;
  localparam int MX = 200;
`ifdef IRRIGATION_RUN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, dry, wet, air, tank;
  logic spr, drp, valve, flt, tmo;

  always #5 clk = ~clk;

  irrigation_mode_controller #(
    .SETTLE_CYCLES (S),
    .MIN_RUN_CYCLES(MN),
    .MAX_RUN_CYCLES(MX),
    .CNT_W         (8)
  ) dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .enable_i          (en),
    .soil_dry_i        (dry),
    .soil_wet_i        (wet),
    .air_dry_i         (air),
    .tank_empty_i      (tank),
    .sprinkler_status_o(spr),
    .drip_status_o     (drp),
    .valve_open_o      (valve),
    .fault_o           (flt),
    .timeout_o         (tmo)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit rst, en, dry, wet, air, tank;
    int n;
    bit spr, drp, flt, to;
  } vec_t;

  vec_t tbl[$];

  // model: 0 idle, 1 settle, 2 sprinkler, 3 drip, 4 fault
  int m_st, m_pend, m_age, m_run;
  bit m_to;
  logic [4:0] exp_o;

  task automatic model_edge(bit r, bit e, bit d, bit w, bit a, bit t);
    int tgt;
    bit fire;
    if (r) begin
      m_st = 0; m_pend = 2; m_age = 0; m_run = 0; m_to = 0;
      exp_o = '0;
      return;
    end
    exp_o = {m_st == 2, m_st == 3, m_st == 2 || m_st == 3,
             m_st == 4, m_to};
    if (!e || t || w || m_to) tgt = 0;
    else if (d)               tgt = a ? 3 : 2;
    else                      tgt = 1;
    fire = 0;
    if (d && w) begin
      m_st = 4;
    end else begin
      case (m_st)
        0: if (tgt >= 2) begin
             m_st = 1; m_pend = tgt; m_age = 0;
           end
        1: if (tgt == 0) m_st = 0;
           else if (tgt >= 2 && tgt != m_pend) begin
             m_pend = tgt; m_age = 0;
           end else if (m_age == S - 1) begin
             m_st = m_pend; m_run = 0;
           end else m_age++;
        2, 3: if (!e || t) m_st = 0;
           else if (TO_EN && m_run == MX - 1) begin
             m_st = 0; fire = 1;
           end else if (m_run >= MN - 1 && w) m_st = 0;
           else if (m_run >= MN - 1 && tgt >= 2 && tgt != m_st) begin
             m_st = 1; m_pend = tgt; m_age = 0;
           end else m_run++;
        default: if (!e) m_st = 0;
      endcase
    end
    if (w || !e) m_to = 0;
    else if (fire) m_to = 1;
  endtask

  task automatic drive(bit r, bit e, bit d, bit w, bit a, bit t);
    rst = r; en = e; dry = d; wet = w; air = a; tank = t;
    @(posedge clk);
    model_edge(r, e, d, w, a, t);
    #1;
  endtask

  task automatic check(string nm, logic [4:0] req);
    logic [4:0] act;
    act = {spr, drp, valve, flt, tmo};
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got spr/drp/vlv/flt/to=%b want %b",
                  nm, act, req);
  endtask

  task automatic row(bit r, bit e, bit d, bit w, bit a, bit t,
                     int n, bit s, bit dp, bit f, bit to);
    vec_t v;
    v.rst = r; v.en = e; v.dry = d; v.wet = w; v.air = a;
    v.tank = t; v.n = n;
    v.spr = s; v.drp = dp; v.flt = f; v.to = to;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1; en = 1; dry = 1; wet = 1; air = 1; tank = 1;

    // reset with all inputs high, then fault from dry & wet
    row(1, 1, 1, 1, 1, 1,  2, 0, 0, 0, 0);
    row(0, 1, 1, 1, 1, 1,  1, 0, 0, 0, 0);
    row(0, 1, 1, 1, 1, 1,  1, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    // sprinkler request: five low cycles, then on
    row(0, 1, 1, 0, 0, 0,  5, 0, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0,  2, 1, 0, 0, 0);
    // air dries at run cycle 3: hold to min run, settle, drip
    row(0, 1, 1, 0, 1, 0, 13, 1, 0, 0, 0);
    row(0, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0);
    row(0, 1, 1, 0, 1, 0,  3, 0, 0, 0, 0);
    row(0, 1, 1, 0, 1, 0,  1, 0, 1, 0, 0);
    row(0, 1, 1, 0, 1, 0,  1, 0, 1, 0, 0);
    // wet soil mid-run: stop only after the minimum run
    row(0, 1, 0, 1, 1, 0, 14, 0, 1, 0, 0);
    row(0, 1, 0, 1, 1, 0,  1, 0, 0, 0, 0);
    // drip again, then tank empty stops immediately
    row(0, 1, 1, 0, 1, 0,  5, 0, 0, 0, 0);
    row(0, 1, 1, 0, 1, 0,  1, 0, 1, 0, 0);
    row(0, 1, 1, 0, 1, 1,  1, 0, 1, 0, 0);
    row(0, 1, 1, 0, 1, 1,  1, 0, 0, 0, 0);
    // fault pulse mid-run, latched until enable drops
    row(0, 1, 1, 0, 0, 0,  5, 0, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0);
    row(0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    row(0, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    row(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
`ifdef IRRIGATION_RUN_TIMEOUT_EN
    // run timeout after 200 cycles, no re-entry, wet clears it
    row(0, 1, 1, 0, 0, 0,   5, 0, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0,   1, 1, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0, 199, 1, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 1);
    row(0, 1, 1, 0, 0, 0,  10, 0, 0, 0, 1);
    row(0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 1);
    row(0, 1, 0, 1, 0, 0,   1, 0, 0, 0, 0);
`else
    // long run without timeout stays on
    row(0, 1, 1, 0, 0, 0,   5, 0, 0, 0, 0);
    row(0, 1, 1, 0, 0, 0, 230, 1, 0, 0, 0);
`endif

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        drive(tbl[i].rst, tbl[i].en, tbl[i].dry, tbl[i].wet,
              tbl[i].air, tbl[i].tank);
      check($sformatf("row%0d", i),
            {tbl[i].spr, tbl[i].drp, tbl[i].spr | tbl[i].drp,
             tbl[i].flt, tbl[i].to});
    end

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    begin
      bit e, d, w, a, t;
      int hold;
      e = 0; d = 0; w = 0; a = 0; t = 0; hold = 0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          e = ($urandom % 16) != 0;
          t = ($urandom % 20) == 0;
          d = ($urandom % 3) != 0;
          w = ($urandom % 4) == 0;
          if (d && w && ($urandom % 8) != 0) w = 0;
          a = $urandom % 2;
          hold = $urandom_range(1, 24);
        end
        hold--;
        drive(0, e, d, w, a, t);
        check($sformatf("rand%0d", c), exp_o);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
